// File: rtl/shift_count_register.sv
// rtl/shift_count_register.sv - clear/load/inc/dec register with multi-bit serial shifter
// Optional build macro SHIFT_COUNT_SATURATE_EN: saturating inc/dec instead of modulo wrap.
module shift_count_register #(
   parameter int DATA_WIDTH  = 16,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cl,
   input  logic                   ld,
   input  logic [DATA_WIDTH-1:0]  in,
   input  logic                   inc,
   input  logic                   dec,
   input  logic                   start,
   input  logic                   dir,
   input  logic [1:0]             mode,
   input  logic [SHAMT_WIDTH-1:0] amount,
   input  logic                   ser_in,
   output logic [DATA_WIDTH-1:0]  out,
   output logic                   busy,
   output logic                   done,
   output logic                   carry,
   output logic                   zero
);
   localparam int DW = DATA_WIDTH;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state;
   logic [SHAMT_WIDTH-1:0] cnt;
   logic                   l_dir;
   logic [1:0]             l_mode;
   logic                   l_ser;

   logic [DW-1:0]          step_out;
   logic                   step_carry;
   logic                   fill;
   logic [DW:0]            inc_sum;
   logic [DW:0]            dec_diff;

   assign zero     = (out == '0);
   assign inc_sum  = {1'b0, out} + (DW+1)'(1);
   assign dec_diff = {1'b0, out} - (DW+1)'(1);

   // One shift step, driven only by the operation parameters latched at start.
   always_comb begin
      fill       = 1'b0;
      step_out   = out;
      step_carry = 1'b0;
      if (l_dir) begin
         step_carry = out[DW-1];
         case (l_mode)
            2'b00:   fill = l_ser;
            2'b10:   fill = out[DW-1];
            default: fill = 1'b0;
         endcase
         step_out = {out[DW-2:0], fill};
      end else begin
         step_carry = out[0];
         case (l_mode)
            2'b00:   fill = l_ser;
            2'b01:   fill = out[DW-1];
            2'b10:   fill = out[0];
            default: fill = 1'b0;
         endcase
         step_out = {fill, out[DW-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         out    <= '0;
         carry  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
         l_dir  <= 1'b0;
         l_mode <= 2'b00;
         l_ser  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cl) begin
                  out   <= '0;
                  carry <= 1'b0;
               end else if (ld) begin
                  out   <= in;
                  carry <= 1'b0;
               end else if (start) begin
                  l_dir  <= dir;
                  l_mode <= mode;
                  l_ser  <= ser_in;
                  cnt    <= amount;
                  if (amount == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy  <= 1'b1;
                     state <= SHIFT;
                  end
               end else if (inc) begin
`ifdef SHIFT_COUNT_SATURATE_EN
                  if (&out) begin
                     carry <= 1'b1;
                  end else begin
                     out   <= inc_sum[DW-1:0];
                     carry <= 1'b0;
                  end
`else
                  out   <= inc_sum[DW-1:0];
                  carry <= inc_sum[DW];
`endif
               end else if (dec) begin
`ifdef SHIFT_COUNT_SATURATE_EN
                  if (out == '0) begin
                     carry <= 1'b1;
                  end else begin
                     out   <= dec_diff[DW-1:0];
                     carry <= 1'b0;
                  end
`else
                  out   <= dec_diff[DW-1:0];
                  carry <= dec_diff[DW];
`endif
               end
            end
            SHIFT: begin
               if (cl) begin
                  out   <= '0;
                  carry <= 1'b0;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  out   <= step_out;
                  carry <= step_carry;
                  cnt   <= cnt - SHAMT_WIDTH'(1);
                  if (cnt == SHAMT_WIDTH'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_shift_count_register.sv
// tb/tb_shift_count_register.sv - scoreboard bench for shift_count_register, DATA_WIDTH=8
// Expectations follow SHIFT_COUNT_SATURATE_EN when the macro is defined.
module tb_shift_count_register;
   localparam int DW = 8;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cl = 1'b0, ld = 1'b0, inc = 1'b0, dec = 1'b0, start = 1'b0;
   logic          dir = 1'b0, ser_in = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [SW-1:0] amount = '0;
   logic [DW-1:0] in = '0;
   logic [DW-1:0] out;
   logic          busy, done, carry, zero;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string         tag;
      logic [DW-1:0] o;
      logic          c;
   } exp_t;
   exp_t exp_q[$];

   shift_count_register #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .cl(cl), .ld(ld), .in(in), .inc(inc), .dec(dec),
      .start(start), .dir(dir), .mode(mode), .amount(amount), .ser_in(ser_in),
      .out(out), .busy(busy), .done(done), .carry(carry), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every done pulse must match the oldest pending shift expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         check("done_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "_out"}, out, e.o);
            check({e.tag, "_carry"}, carry, e.c);
         end
      end
   end

   task automatic op(input logic c, input logic l, input logic [DW-1:0] d,
                     input logic i, input logic de);
      @(negedge clk);
      cl = c; ld = l; in = d; inc = i; dec = de;
      @(negedge clk);
      cl = 0; ld = 0; inc = 0; dec = 0;
   endtask

   task automatic run_shift(input string tag, input logic d, input logic [1:0] m,
                            input logic [SW-1:0] amt, input logic s,
                            input logic [DW-1:0] eo, input logic ec, input logic noise);
      int bc;
      bit seen;
      @(negedge clk);
      start = 1; dir = d; mode = m; amount = amt; ser_in = s;
      exp_q.push_back('{tag, eo, ec});
      @(negedge clk);
      start = 0; dir = ~d; mode = ~m; amount = '1; ser_in = ~s;
      bc = 0;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (done) begin
            seen = 1;
            ld = 0; inc = 0;
         end else begin
            if (busy) bc++;
            if (noise) begin ld = 1; in = 8'hAA; inc = 1; end
            @(negedge clk);
         end
      end
      check({tag, "_seen_done"}, seen, 1);
      check({tag, "_busy_cycles"}, bc, amt);
      check({tag, "_busy_at_done"}, busy, 0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      check("rst_out", out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_carry", carry, 0);
      check("rst_zero", zero, 1);
      @(negedge clk);
      rst = 0;

      // 1: rotate left by 3
      op(0, 1, 8'h96, 0, 0);
      run_shift("rotl3", 1, 2'b10, 3, 0, 8'hB4, 0, 0);

      // 2: arithmetic right, then serial-fill right
      op(0, 1, 8'h90, 0, 0);
      run_shift("asr2", 0, 2'b01, 2, 0, 8'hE4, 0, 0);
      op(0, 1, 8'h01, 0, 0);
      run_shift("lsr_ser1", 0, 2'b00, 1, 1, 8'h80, 1, 0);

      // 3: inc/dec boundaries
`ifdef SHIFT_COUNT_SATURATE_EN
      op(0, 1, 8'hFF, 0, 0);
      op(0, 0, 8'h00, 1, 0);
      check("sat_inc_out", out, 8'hFF);
      check("sat_inc_carry", carry, 1);
      op(0, 1, 8'h00, 0, 0);
      op(0, 0, 8'h00, 0, 1);
      check("sat_dec_out", out, 8'h00);
      check("sat_dec_carry", carry, 1);
      check("sat_dec_zero", zero, 1);
`else
      op(0, 1, 8'hFF, 0, 0);
      op(0, 0, 8'h00, 1, 0);
      check("inc_wrap_out", out, 8'h00);
      check("inc_wrap_carry", carry, 1);
      check("inc_wrap_zero", zero, 1);
      op(0, 0, 8'h00, 0, 1);
      check("dec_wrap_out", out, 8'hFF);
      check("dec_wrap_carry", carry, 1);
      check("dec_wrap_zero", zero, 0);
`endif
      op(0, 1, 8'h05, 0, 0);
      op(0, 0, 8'h00, 1, 0);
      check("inc_out", out, 8'h06);
      check("inc_carry", carry, 0);
      op(0, 0, 8'h00, 0, 1);
      check("dec_out", out, 8'h05);
      check("dec_carry", carry, 0);
      op(0, 0, 8'h00, 1, 1);
      check("inc_over_dec", out, 8'h06);

      // 4: clear aborts a shift; ld/inc ignored while shifting
      op(0, 1, 8'h0F, 0, 0);
      @(negedge clk);
      start = 1; dir = 0; mode = 2'b11; amount = 5;
      @(negedge clk);
      start = 0;
      check("abort_busy1", busy, 1);
      @(negedge clk);
      check("abort_busy2", busy, 1);
      check("abort_mid_carry", carry, 1);
      cl = 1;
      @(negedge clk);
      cl = 0;
      check("abort_out", out, 0);
      check("abort_carry", carry, 0);
      check("abort_busy", busy, 0);
      repeat (6) @(negedge clk);
      check("abort_no_done", done, 0);
      op(0, 1, 8'h0F, 0, 0);
      run_shift("noise_lsr3", 0, 2'b11, 3, 0, 8'h01, 1, 1);

      // 5: zero-length shift, and load beating start
      op(0, 1, 8'h5A, 0, 0);
      run_shift("amt0", 1, 2'b00, 0, 1, 8'h5A, 0, 0);
      @(negedge clk);
      start = 1; ld = 1; in = 8'h3C; amount = 2;
      @(negedge clk);
      start = 0; ld = 0;
      check("ld_wins_out", out, 8'h3C);
      check("ld_wins_busy", busy, 0);
      repeat (3) @(negedge clk);
      check("ld_wins_no_busy", busy, 0);

      // 6: asynchronous reset mid-shift, then rotate right by 9
      op(0, 1, 8'h55, 0, 0);
      @(negedge clk);
      start = 1; dir = 1; mode = 2'b10; amount = 6;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      #2 rst = 1;
      #1;
      check("async_rst_out", out, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      @(negedge clk);
      rst = 0;
      repeat (2) @(negedge clk);
      check("post_rst_idle", busy, 0);
      op(0, 1, 8'h81, 0, 0);
      run_shift("rotr9", 0, 2'b10, 9, 0, 8'hC0, 1, 0);

      repeat (2) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
